// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage. Owns the program counter, presents the word address
// to instruction memory, and captures the returned word into a registered
// IF/ID output that is handed to decode with a valid/ready handshake. Branch
// redirects from execute take priority over everything else. Fetching stops
// once the PC leaves the program image (0..DEPTH-1).
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   instr_addr     word address to instruction memory (0 when PC out of range)
//   instruction    combinational read data from instruction memory
//   branch_valid   one-cycle redirect request
//   branch_target  redirect word address
//   out_valid      IF/ID register holds an instruction
//   out_ready      decode accepts the IF/ID register this cycle
//   out_instr      fetched instruction word
//   out_pc         word address of out_instr
//   halted         fetch stopped
//   fetch_count    fetches issued since reset (wraps)
module fetch_unit #(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] instr_addr,
  input  logic [31:0] instruction,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [31:0] DEPTH_W    = 32'(DEPTH);
  localparam logic [31:0] LAST_PC_W  = DEPTH_W - 32'd1;
  // The memory address is clamped to 0 whenever the PC is out of range.
  localparam logic [31:0] RESET_ADDR = (RESET_PC < DEPTH_W) ? RESET_PC : 32'd0;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] pc_r;
  logic [31:0] pc_next_s;
  logic [31:0] addr_r;
  logic        out_valid_r;
  logic [31:0] out_instr_r;
  logic [31:0] out_pc_r;
  logic        halted_r;
  logic [31:0] fetch_count_r;
  logic        in_range_s;
  logic        fire_s;

  // Fetch decision and next PC / next state.
  always_comb begin
    pc_next_s    = pc_r;
    state_next_s = state_r;
    in_range_s   = (pc_r < DEPTH_W);
    fire_s       = (state_r == RUN) && in_range_s && !branch_valid &&
                   (!out_valid_r || out_ready);
    if (branch_valid) begin
      pc_next_s    = branch_target;
      state_next_s = (branch_target < DEPTH_W) ? RUN : HALT;
    end else if (fire_s) begin
      pc_next_s = pc_r + 32'd1;
      // The last word of the image still gets fetched; halt right after it.
      if (pc_r == LAST_PC_W) begin
        state_next_s = HALT;
      end else begin
        state_next_s = state_r;
      end
    end else if ((state_r == RUN) && !in_range_s) begin
      state_next_s = HALT;
    end else begin
      state_next_s = state_r;
    end
  end

  // PC, FSM state, memory address and IF/ID register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= RUN;
      pc_r          <= RESET_PC;
      addr_r        <= RESET_ADDR;
      halted_r      <= 1'b0;
      out_valid_r   <= 1'b0;
      out_instr_r   <= 32'd0;
      out_pc_r      <= 32'd0;
      fetch_count_r <= 32'd0;
    end else begin
      state_r  <= state_next_s;
      pc_r     <= pc_next_s;
      // Address is registered from the next PC so it always tracks pc_r.
      addr_r   <= (pc_next_s < DEPTH_W) ? pc_next_s : 32'd0;
      halted_r <= (state_next_s == HALT);
      if (branch_valid) begin
        // Flush the wrong-path word; an accepting decode has already taken it.
        out_valid_r <= 1'b0;
      end else if (fire_s) begin
        out_valid_r   <= 1'b1;
        out_instr_r   <= instruction;
        out_pc_r      <= pc_r;
        fetch_count_r <= fetch_count_r + 32'd1;
      end else if (out_ready) begin
        // Drain: decode took the last word and nothing replaces it.
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign instr_addr  = addr_r;
  assign out_valid   = out_valid_r;
  assign out_instr   = out_instr_r;
  assign out_pc      = out_pc_r;
  assign halted      = halted_r;
  assign fetch_count = fetch_count_r;

endmodule
